// File: rtl/cmp_lteq_arbiter.sv
// cmp_lteq_arbiter: round-robin sequencer sharing one signed <= comparator
// among NREQ requesters, returning tagged results on a single response channel.
module cmp_lteq_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDW   = 2,
   parameter int unsigned CNTW  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_lteq,
   output logic                    busy,
   output logic [CNTW-1:0]         done_cnt
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t             state;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      id_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;

   logic               grant_vld;
   logic [IW-1:0]      grant_idx;
   logic [IW:0]        search_idx;
   logic [WIDTH-1:0]   grant_a;
   logic [WIDTH-1:0]   grant_b;
   logic [IW-1:0]      next_ptr;
   logic               accept;
   logic               lteq_c;

   // Full two's-complement compare: differing signs decide by A's sign,
   // otherwise an unsigned compare of the raw bits is exact.
   function automatic logic signed_lteq(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
      logic r;
      if (a[WIDTH-1] != b[WIDTH-1]) begin
         r = a[WIDTH-1];
      end else begin
         r = (a <= b);
      end
      return r;
   endfunction

   // Round-robin search: first valid requester starting at rr_ptr, wrapping.
   always_comb begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      search_idx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         search_idx = {1'b0, rr_ptr} + (IW+1)'(k);
         if (search_idx >= (IW+1)'(NREQ)) begin
            search_idx = search_idx - (IW+1)'(NREQ);
         end
         if (!grant_vld && req_valid[IW'(search_idx)]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(search_idx);
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      grant_a = '0;
      grant_b = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (IW'(k) == grant_idx) begin
            grant_a = req_a[k*WIDTH +: WIDTH];
            grant_b = req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept toward the granted requester, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == S_IDLE) && grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign accept   = (state == S_IDLE) && grant_vld;
   assign next_ptr = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
   assign lteq_c   = signed_lteq(a_q, b_q);
   assign busy     = (state != S_IDLE);

   // Sequencer: accept -> compare -> hold result until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_lteq  <= 1'b0;
         done_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_q    <= grant_a;
                  b_q    <= grant_b;
                  id_q   <= grant_idx;
                  rr_ptr <= next_ptr;
                  state  <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               rsp_lteq  <= lteq_c;
               rsp_id    <= IDW'(id_q);
               rsp_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  done_cnt  <= done_cnt + CNTW'(1);
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_lteq_arbiter.sv
// Bench for cmp_lteq_arbiter: comparator vector table, directed arbitration,
// backpressure and reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_cmp_lteq_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_a;
   logic [NREQ*W-1:0]    req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic                 rsp_lteq;
   logic                 busy;
   logic [CNTW-1:0]      done_cnt;

   cmp_lteq_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_lteq(rsp_lteq),
      .busy(busy), .done_cnt(done_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: one outstanding op, round-robin pointer, completion count
   int  m_rr = 0;
   bit  m_pend = 0;
   int  m_rsp_cyc = 0;
   int  m_id = 0;
   bit  m_lteq = 0;
   int  m_done = 0;

   // observations
   int  acc_id_q[$];
   int  acc_cyc_q[$];
   int  rsp_id_q[$];
   int  acc_cyc_last = 0;
   int  hs_cyc = 0;
   int  hs_id = 0;
   logic hs_lteq = 1'b0;

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
         if (n_bad >= 100) begin
            summary();
            $finish;
         end
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
   endtask

   // One clock: compare outputs against the model before the edge, then advance.
   task automatic cycle(output int dacc, output bit hs);
      int g;
      bit ev;
      bit rdy;
      bit nlteq;
      logic [NREQ-1:0] er;
      #2;
      g = -1;
      nlteq = 1'b0;
      if (!m_pend) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = m_pend && (cyc >= m_rsp_cyc);
      rdy = rsp_ready;
      check("req_ready", 64'(req_ready), 64'(er));
      check("busy", 64'(busy), 64'(m_pend));
      check("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
         check("rsp_id", 64'(rsp_id), 64'(m_id));
         check("rsp_lteq", 64'(rsp_lteq), 64'(m_lteq));
      end
      check("done_cnt", 64'(done_cnt), 64'(m_done));
      dacc = -1;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i] === 1'b1) dacc = i;
      end
      hs = (rsp_valid === 1'b1) && rdy;
      if (dacc >= 0) begin
         acc_id_q.push_back(dacc);
         acc_cyc_q.push_back(cyc);
         acc_cyc_last = cyc;
      end
      if (hs) begin
         rsp_id_q.push_back(int'(rsp_id));
         hs_lteq = rsp_lteq;
         hs_id   = int'(rsp_id);
         hs_cyc  = cyc;
      end
      if (g >= 0) nlteq = ($signed(req_a[g*W +: W]) <= $signed(req_b[g*W +: W]));
      @(posedge clk);
      #1;
      cyc++;
      if (g >= 0) begin
         m_pend    = 1'b1;
         m_rsp_cyc = cyc + 1;
         m_id      = g;
         m_lteq    = nlteq;
         m_rr      = (g + 1) % NREQ;
      end else if (ev && rdy) begin
         m_pend = 1'b0;
         m_done = (m_done + 1) % (1 << CNTW);
      end
   endtask

   // Asynchronous reset held across one clock edge; outputs must clear at once.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_id", 64'(rsp_id), 64'(0));
      check("rst_rsp_lteq", 64'(rsp_lteq), 64'(0));
      check("rst_done_cnt", 64'(done_cnt), 64'(0));
      m_pend = 1'b0;
      m_rr   = 0;
      m_done = 0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pick_b(input logic [31:0] a);
      case ($urandom_range(0, 5))
         0: return a;
         1: return a + 32'd1;
         2: return a - 32'd1;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_req(input int i);
      logic [31:0] a;
      a = $urandom();
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = pick_b(a);
      req_valid[i] = 1'b1;
   endtask

   // Single operation from requester r; returns the DUT's response and latency.
   task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        output logic lt, output int id, output int lat);
      int acc;
      bit hs;
      bit got;
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
      rsp_ready = 1'b1;
      got = 1'b0;
      lt = 1'bx;
      id = -1;
      lat = -1;
      for (int n = 0; n < 12 && !got; n++) begin
         cycle(acc, hs);
         if (acc >= 0) req_valid = '0;
         if (hs) begin
            got = 1'b1;
            lt  = hs_lteq;
            id  = hs_id;
            lat = hs_cyc - acc_cyc_last;
         end
      end
      if (!got) timeout("op_response");
   endtask

   typedef struct {
      int          r;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      summary();
      $fatal(1);
   end

   initial begin
      int acc;
      bit hs;
      logic lt;
      int id;
      int lat;
      int ops;
      int ncyc;

      tbl[0]  = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tbl[1]  = '{2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
      tbl[2]  = '{2, 32'h8000_0000, 32'h8000_0000, 1'b1};
      tbl[3]  = '{2, 32'h0000_0005, 32'h0000_0004, 1'b0};
      tbl[4]  = '{1, 32'h0000_0004, 32'h0000_0005, 1'b1};
      tbl[5]  = '{3, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[6]  = '{0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
      tbl[7]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
      tbl[8]  = '{2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1};
      tbl[9]  = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      tbl[10] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      tbl[11] = '{1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};

      rst_n = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      #2;
      do_reset();

      // comparator vectors through the full handshake
      for (int t = 0; t < 12; t++) begin
         do_op(tbl[t].r, tbl[t].a, tbl[t].b, lt, id, lat);
         check($sformatf("vec%0d_lteq", t), 64'(lt), 64'(tbl[t].exp));
         check($sformatf("vec%0d_id", t), 64'(id), 64'(tbl[t].r));
         if (t == 0) begin
            check("first_latency", 64'(lat), 64'(2));
            check("first_done_cnt", 64'(done_cnt), 64'(1));
         end
      end

      // all requesters valid continuously: strict rotation, one accept per 3 cycles
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i);
      rsp_ready = 1'b1;
      acc_id_q.delete();
      acc_cyc_q.delete();
      rsp_id_q.delete();
      for (int n = 0; n < 20; n++) cycle(acc, hs);
      req_valid = '0;
      if (acc_id_q.size() < 6 || rsp_id_q.size() < 6) begin
         timeout("rr_sequence");
      end else begin
         for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_grant%0d", k), 64'(acc_id_q[k]), 64'(k % NREQ));
            check($sformatf("rr_rsp_id%0d", k), 64'(rsp_id_q[k]), 64'(k % NREQ));
            if (k > 0) check($sformatf("rr_spacing%0d", k),
                             64'(acc_cyc_q[k] - acc_cyc_q[k-1]), 64'(3));
         end
      end
      for (int n = 0; n < 4; n++) cycle(acc, hs);

      // backpressure: result held stable, no new accepts, count frozen
      do_reset();
      req_valid = '0;
      req_valid[3] = 1'b1;
      req_a[3*W +: W] = 32'hFFFF_FFF9;
      req_b[3*W +: W] = 32'hFFFF_FFFB;
      rsp_ready = 1'b0;
      begin : wait_rsp
         for (int n = 0; n < 6; n++) begin
            cycle(acc, hs);
            if (acc >= 0) req_valid = '0;
            if (rsp_valid === 1'b1) disable wait_rsp;
         end
      end
      if (rsp_valid !== 1'b1) timeout("bp_rsp_valid");
      for (int i = 0; i < NREQ; i++) set_req(i);
      for (int n = 0; n < 5; n++) begin
         #1;
         check($sformatf("bp_valid%0d", n), 64'(rsp_valid), 64'(1));
         check($sformatf("bp_id%0d", n), 64'(rsp_id), 64'(3));
         check($sformatf("bp_lteq%0d", n), 64'(rsp_lteq), 64'(1));
         check($sformatf("bp_ready%0d", n), 64'(req_ready), 64'(0));
         check($sformatf("bp_done%0d", n), 64'(done_cnt), 64'(0));
         cycle(acc, hs);
      end
      rsp_ready = 1'b1;
      cycle(acc, hs);
      check("bp_handshake", 64'(hs), 64'(1));
      check("bp_no_overlap", 64'(acc), 64'(-1));
      req_valid = '0;
      #1;
      check("bp_idle_after", 64'(busy), 64'(0));
      check("bp_done_after", 64'(done_cnt), 64'(1));
      cycle(acc, hs);

      // reset during COMPARE drops the result and restarts arbitration at 0
      do_reset();
      req_valid = 4'b1010;
      req_a = {NREQ*W{1'b0}};
      req_b = {NREQ*W{1'b0}};
      rsp_ready = 1'b1;
      cycle(acc, hs);
      check("mid_first_grant", 64'(acc), 64'(1));
      do_reset();
      req_valid = 4'b1010;
      cycle(acc, hs);
      check("mid_regrant", 64'(acc), 64'(1));
      req_valid = '0;
      for (int n = 0; n < 3; n++) cycle(acc, hs);

      // done_cnt wraps modulo 2**CNTW
      do_reset();
      for (int n = 0; n < 17; n++) begin
         do_op(n % NREQ, $urandom(), $urandom(), lt, id, lat);
      end
      check("wrap_done_cnt", 64'(done_cnt), 64'(1));

      // randomized traffic against the reference model
      do_reset();
      req_valid = '0;
      ops = 0;
      ncyc = 0;
      while (ops < 10000 && ncyc < 60000) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle(acc, hs);
         if (acc >= 0) req_valid[acc] = 1'b0;
         if (hs) ops++;
         ncyc++;
      end
      if (ops < 10000) timeout("random_ops");

      summary();
      $finish;
   end

endmodule

// File: doc/cmp_lteq_arbiter.md
Name: cmp_lteq_arbiter

Overview:
- Shares one 32-bit signed less-than-or-equal comparator among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester at a time.
- Operands are registered and compared, and the result is returned on a single tagged response channel with backpressure.
- Sits in front of the signed lteq comparator datapath as its sequencer and sharing controller.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, operand width in bits, two's complement.
- IDW, 2, response tag width; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  input  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  packed operand B, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_lteq  output  1  1 when $signed(A) <= $signed(B).
- busy  output  1  1 whenever state != IDLE.
- done_cnt  output  CNTW  count of completed response handshakes; wraps modulo 2**CNTW.

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_lteq=0, done_cnt=0, operand registers=0. req_ready is 0 while rst_n=0.
- FSM states: IDLE, COMPARE, HOLD.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant]=1, combinational from req_valid and rr_ptr; all other bits 0.
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On accept (the clock edge with req_valid[g] & req_ready[g]):
    - a_q<=A[g], b_q<=B[g], id_q<=g.
    - rr_ptr <= (g+1) mod NREQ.
    - state<=COMPARE.
- COMPARE:
  - req_ready=0.
  - Comparator evaluates a_q,b_q; rsp_lteq<=result, rsp_id<=id_q, rsp_valid<=1.
  - state<=HOLD.
- HOLD:
  - rsp_valid=1; rsp_id and rsp_lteq are held stable until the handshake.
  - On rsp_valid & rsp_ready: rsp_valid<=0, done_cnt<=done_cnt+1 (wraps), state<=IDLE.
  - req_ready=0 throughout HOLD, including the handshake cycle (no accept overlap).
- Latency: accept at edge T -> rsp_valid=1 from edge T+1 (visible in cycle T+1..).
  - Precisely: accept edge E0; COMPARE during the next cycle; rsp_valid rises at edge E1.
- Throughput: at most one operation per 3 cycles (IDLE, COMPARE, HOLD with rsp_ready=1).
- Comparison rule:
  - Full signed compare: the sign bits differ -> lteq = sign(A).
  - Otherwise, lteq = (A_unsigned <= B_unsigned).
  - Equality gives 1.
- Requesters must hold req_valid and their operands stable until accepted. The arbiter does not register unaccepted requests.
- rr_ptr changes only on accept; deasserting a request before grant has no side effect.
- Simultaneous requests:
  - Exactly one is granted, per the round-robin rule.
  - A continuously valid requester is served within NREQ grants (no starvation).
- Reset mid-operation: any pending result is dropped, rsp_valid falls immediately (async), and rr_ptr returns to 0.
- rsp_ready while rsp_valid=0 is ignored.
- done_cnt at 2**CNTW-1 plus a handshake -> 0.

Test Plan:
- Single requester 0: A=32'hFFFFFFFF (-1), B=0 -> req_ready[0] high in IDLE; rsp_valid 2 edges after accept; rsp_id=0, rsp_lteq=1; done_cnt=1.
- Requester 2 alone: A=32'h7FFFFFFF, B=32'h80000000 -> rsp_lteq=0, rsp_id=2. Then A=B=32'h80000000 -> rsp_lteq=1. Then A=5, B=4 -> rsp_lteq=0.
- All four valid continuously from reset, rsp_ready=1 -> grants and rsp_id sequence 0,1,2,3,0,1. The next accept occurs exactly 3 cycles after each previous one.
- Backpressure: hold rsp_ready=0 for 5 cycles in HOLD -> rsp_valid, rsp_id and rsp_lteq stay stable, req_ready stays 0 for all requesters, and done_cnt is unchanged. Release -> single handshake, then IDLE.
- Reset pulse (rst_n=0 for 1 cycle) during COMPARE with requesters 1 and 3 valid -> rsp_valid=0 and busy=0 immediately. After release, requester 1 is granted first (rr_ptr=0).
- Wrap check with CNTW=4: 17 completed ops -> done_cnt=1. Also randomized operands versus the signed <= golden model over 10k ops: zero mismatches.
